// File: rtl/rs_gf_pkg.sv
// rs_gf_pkg
// Shared GF(2^5) definitions for the Reed-Solomon decoder: symbol type,
// field constants, the alpha power table and a constant-foldable multiplier.
// Field: primitive polynomial x^5+x^2+1, bit k of a symbol is the x^k term.
package rs_gf_pkg;

  localparam int GF_W  = 5;
  localparam int RS_N  = 31;

  typedef logic [GF_W-1:0] gf_sym_t;

  // Low-order terms of x^5+x^2+1; x^5 itself is implied by the overflow bit.
  localparam gf_sym_t PRIM_POLY = 5'b00101;

  // ALPHA_POW[i] = alpha^i, alpha = x.
  localparam gf_sym_t ALPHA_POW [0:RS_N-1] = '{
    5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00101, 5'b01010,
    5'b10100, 5'b01101, 5'b11010, 5'b10001, 5'b00111, 5'b01110, 5'b11100,
    5'b11101, 5'b11111, 5'b11011, 5'b10011, 5'b00011, 5'b00110, 5'b01100,
    5'b11000, 5'b10101, 5'b01111, 5'b11110, 5'b11001, 5'b10111, 5'b01011,
    5'b10110, 5'b01001, 5'b10010
  };

  // Shift-and-add GF multiply, reducing by PRIM_POLY on each shift. With one
  // operand constant this folds into a small XOR network.
  function automatic gf_sym_t gf_mul(input gf_sym_t a, input gf_sym_t b);
    gf_sym_t p;
    gf_sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[GF_W-2:0], 1'b0} ^ (x[GF_W-1] ? PRIM_POLY : gf_sym_t'(0));
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_syn_cell.sv
// rs_syn_cell
// One Horner accumulator for syndrome S_J: acc <= acc * alpha^J ^ symbol,
// or acc <= symbol when load_first marks the first symbol of a codeword.
// Ports:
//   clock, reset (active-low, asynchronous)
//   en          - a symbol is accepted this cycle
//   load_first  - accepted symbol is the first of its codeword
//   in_symbol   - received symbol
//   acc         - current accumulator value
//   nxt         - value the accumulator takes on an accepted symbol
module rs_syn_cell
  import rs_gf_pkg::*;
#(
  parameter int J = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    en,
  input  logic    load_first,
  input  gf_sym_t in_symbol,
  output gf_sym_t acc,
  output gf_sym_t nxt
);

  localparam gf_sym_t MULT = ALPHA_POW[J];

  // Loading the first symbol directly avoids a separate clear cycle
  // between back-to-back codewords.
  always_comb begin
    nxt = load_first ? in_symbol : (gf_mul(acc, MULT) ^ in_symbol);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  acc <= '0;
    else if (en) acc <= nxt;
  end

endmodule

// File: rtl/rs_syndrome.sv
// rs_syndrome
// Syndrome calculator: accepts one received symbol per cycle (r30 first),
// accumulates NSYN syndromes and hands them off on a double-buffered
// valid/ready output register, so the next codeword accumulates while the
// current result waits for the consumer.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_symbol   - symbol input handshake
//   out_valid/out_ready           - syndrome set handshake
//   out_syn      - S_j at bits [5j-1:5j-5], j = 1..NSYN
//   out_nonzero  - some S_j is nonzero (error detected), qualified by out_valid
// Legal NSYN range is 2..8. Codeword alignment comes from reset only.
module rs_syndrome
  import rs_gf_pkg::*;
#(
  parameter int N    = RS_N,
  parameter int NSYN = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [GF_W-1:0]    in_symbol,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [GF_W*NSYN-1:0] out_syn,
  output logic               out_nonzero
);

  localparam int CNT_W = $clog2(N);

  logic [CNT_W-1:0]     cnt;
  logic                 first_sym;
  logic                 last_sym;
  logic                 accept;
  logic                 complete;
  logic [GF_W*NSYN-1:0] syn_nxt;

  assign first_sym = (cnt == '0);
  assign last_sym  = (cnt == CNT_W'(N - 1));

  // Only the final symbol can stall: it would overwrite a set the consumer
  // has not yet taken.
  assign in_ready = !(last_sym && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && last_sym;

  for (genvar j = 1; j <= NSYN; j++) begin : g_cell
    gf_sym_t acc_unused;
    gf_sym_t nxt_j;

    rs_syn_cell #(.J(j)) u_cell (
      .clock      (clock),
      .reset      (reset),
      .en         (accept),
      .load_first (first_sym),
      .in_symbol  (in_symbol),
      .acc        (acc_unused),
      .nxt        (nxt_j)
    );

    assign syn_nxt[GF_W*j-1 -: GF_W] = nxt_j;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last_sym ? '0 : cnt + CNT_W'(1);
    end
  end

  // Output register: a completion loads the final (post-update) syndromes;
  // a consume without a same-edge completion empties it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_syn     <= '0;
      out_nonzero <= 1'b0;
    end else if (complete) begin
      out_valid   <= 1'b1;
      out_syn     <= syn_nxt;
      out_nonzero <= |syn_nxt;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: doc/rs_syndrome.md
# rs_syndrome

Syndrome calculator for the GF(2^5) Reed-Solomon decoder. It is the first stage after the received-symbol input and feeds the key-equation solver. It accepts one 5-bit received symbol per cycle, accumulates NSYN syndromes by Horner's rule, and presents them on a valid/ready output register. The output is double-buffered, so accumulation of the next codeword overlaps hand-off of the current result.

## Interface
- N, 31: codeword length in symbols.
- NSYN, 4: number of syndromes, equal to 2t. Legal values are 2 to 8.
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_symbol is presented.
- in_ready  output  1  block accepts in_symbol this cycle.
- in_symbol  input  5  received symbol. Highest-degree coefficient (r30) arrives first.
- out_valid  output  1  syndrome set is held for the downstream stage.
- out_ready  input  1  downstream stage consumes the set.
- out_syn  output  5*NSYN  S_j occupies bits [5j-1:5j-5], j = 1..NSYN.
- out_nonzero  output  1  at least one S_j ≠ 0 (error detected). Qualified by out_valid.

## Operation
- Field convention:
  - GF(2^5) with primitive polynomial x^5+x^2+1.
  - Symbol bit k is the coefficient of x^k; bit 4 is the MSB.
  - α = 5'b00010.
- Accept: a symbol is accepted when in_valid && in_ready.
- Symbol counter cnt runs 0..N-1 and advances only on accept. It wraps to 0 after N-1.
- Accumulator update on accept, for each j = 1..NSYN:
  - cnt==0: acc_j <= in_symbol. This loads the first symbol, so no clear cycle is needed.
  - otherwise: acc_j <= acc_j·α^j ⊕ in_symbol.
- Multiplication is by the constant α^j from the package table. All arithmetic is GF: XOR for add, with the same reduction as the existing parallel multiplier.
- Completion: on accept with cnt==N-1:
  - out_syn is loaded with the final values, i.e. the update result above, not the old acc.
  - out_nonzero is loaded with the OR of all final syndromes.
  - out_valid is set.
- Output handshake:
  - out_valid falls on the cycle after out_valid && out_ready, unless a new completion loads at that same edge. In that case out_valid stays 1 with the new data.
  - out_syn and out_nonzero hold while out_valid && !out_ready.
- Backpressure: in_ready = !(cnt==N-1 && out_valid && !out_ready).
  - Only the final symbol of a codeword can stall.
  - Symbols 0..N-2 are always accepted.
- No input framing signal exists. Codeword alignment is established by reset only.

## Timing
- Reset values: cnt=0, every acc_j=0, out_valid=0, out_syn=0, out_nonzero=0. in_ready=1 after reset.
- Latency: last symbol accepted at edge k; out_valid=1 with valid data from edge k (visible cycle k+1).
- Throughput: one symbol per cycle with out_ready held high; no bubbles between codewords.
- Simultaneous events:
  - Completion together with out_ready=1 and out_valid=1: the old set is consumed and the new set is loaded on the same edge.
  - Completion with out_valid=1 and out_ready=0: in_ready=0, so no load occurs. The final symbol waits.
- Reset mid-codeword: the partial codeword is discarded, cnt=0, and the pending output is dropped. The next accepted symbol is treated as r30.
- in_ready is combinational from cnt, out_valid and out_ready. There is no combinational path from in_valid to out_*.

## Structure
- Package rs_gf_pkg contains:
  - GF_W=5.
  - RS_N=31.
  - PRIM_POLY=5'b00101 (low terms of x^5+x^2+1).
  - ALPHA_POW[0:30] power table. The first entries are 00001, 00010, 00100, 01000, 10000, 00101, and so on.
  - gf_sym_t typedef.
- Sub-module rs_syn_cell holds one accumulator. It has:
  - parameter J;
  - the constant multiplier by ALPHA_POW[J] and the XOR with in_symbol;
  - the acc register with load-first and enable inputs.
- The top level contains NSYN rs_syn_cell instances, the counter, the output register and the handshake logic.

## Test plan
- All-zero codeword, out_ready=1 → out_syn all 0, out_nonzero=0, out_valid for exactly 1 cycle, 31 cycles after the first accept.
- Single error r0=00001 (last symbol), all others 0 → S1..S4 = 00001, 00001, 00001, 00001; out_nonzero=1.
- Single error r1=00001 (second-to-last symbol) → S1..S4 = 00010, 00100, 01000, 10000.
- Single error r30=00001 (first symbol) → S1=α^30=10010 and S_j = α^(30j mod 31) from the table. Back-to-back with a zero codeword must give all-zero syndromes for the second codeword.
- Backpressure: out_ready=0 while the next codeword's last symbol arrives → in_ready=0 and the first set is held unchanged. Raising out_ready → the first set is consumed, the last symbol is accepted the same cycle, and the second set is valid the next cycle.
- Reset asserted after 10 symbols → outputs are 0 immediately; a following full codeword with r0=00001 gives all S_j=00001.
